// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and a future receiver).
//   tx_state_t     : frame sequencing states
//   UART_DATA_BITS : data bits per frame (8N1)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
//   clk, reset : clock and synchronous active-high flush
//   push, push_data : write request (ignored while full)
//   pop, pop_data   : read request (ignored while empty); pop_data shows the head
//   full, empty, level : occupancy status
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // The head is visible combinationally so the transmitter can load it on
  // the same edge that pops it.
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter.
//   clk, reset : clock and synchronous active-high reset
//   data_in, valid, ready : byte enqueue handshake (push on valid && ready)
//   tx    : registered UART line, idle high
//   busy  : frame in progress or bytes still queued
//   level : FIFO occupancy
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 2083,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  tx_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;

  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_done;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (valid && ready),
    .push_data (data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign ready    = !reset && !fifo_full;
  assign busy     = (state_reg != IDLE) || (level != '0);
  assign tx       = tx_reg;
  assign bit_done = (cnt_reg == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;

    // The line level is decided from the current state and registered, so
    // tx trails the state by one cycle while every bit still lasts BAUD_DIV.
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == 3'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uart_buffered_tx.md
UART_BUFFERED_TX -- requirements
Module: uart_buffered_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 2083, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning TX byte FIFO entries (power of two, 2..64).
REQ-003 The block SHALL have port clk, input, 1 bit: module clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port data_in, input, 8 bits: byte to enqueue.
REQ-006 The block SHALL have port valid, input, 1 bit: data_in is offered this cycle.
REQ-007 The block SHALL have port ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port tx, output, 1 bit: UART line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-011 The block SHALL transmit frames of 8N1: start bit 0, data bits LSB first, stop bit 1.
REQ-012 Each bit SHALL last exactly BAUD_DIV clk cycles, timed by a single-clock-domain counter (no derived clocks).
REQ-013 A push SHALL occur on a cycle with valid && ready, writing data_in at the tail; ready SHALL equal !full and reset_n-qualified (0 during reset).
REQ-014 The FSM SHALL have states IDLE, START, DATA, and STOP, with a 3-bit bit index in DATA.
REQ-015 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a shift register and enter START; tx falls on the next cycle.
REQ-016 A byte pushed into an empty FIFO while the FSM is in IDLE SHALL drive tx low exactly 2 cycles after the push edge.
REQ-017 Transitions SHALL be START->DATA, DATA(bit 7 done)->STOP, after BAUD_DIV cycles per bit.
REQ-018 At the end of STOP, the FSM SHALL pop and enter START directly if the FIFO is non-empty (frames back-to-back, 10*BAUD_DIV cycles each), otherwise it enters IDLE.
REQ-019 On simultaneous push and pop, the FIFO SHALL perform both and leave level unchanged; when full, push SHALL be blocked by ready=0 while the pop proceeds.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH nor underflow.
REQ-021 valid while ready=0 SHALL be ignored without corrupting state.
REQ-022 busy SHALL be 1 whenever state!=IDLE or level!=0; tx SHALL be registered (glitch-free).

Reset
REQ-023 While reset is high, the block SHALL force tx=1, busy=0, level=0, ready=0, state=IDLE, and the bit counter and index to 0, and flush the FIFO.
REQ-024 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next edge; no partial frame resumes afterward.
REQ-025 ready SHALL return to 1 on the first cycle after reset deasserts.

Structure
REQ-026 Package uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and the UART_DATA_BITS=8 constant, shared with the receiver.
REQ-027 The FIFO SHALL be sub-module uart_sync_fifo (parameters WIDTH and DEPTH; ports push/pop/full/empty/level), reusable for an RX buffer.
REQ-028 The FSM, baud counter, and shift register SHALL reside in uart_buffered_tx.

Verification (BAUD_DIV=4, FIFO_DEPTH=8)
REQ-029 Push 0xA5 when idle -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 total), then busy=0.
REQ-030 Push 0x00 then 0xFF on consecutive cycles -> two contiguous frames with no idle gap, 80 cycles, and level 1->0 at the second pop.
REQ-031 Hold valid=1 for 12 cycles from idle -> 9 bytes accepted (1 popped plus 8 queued), ready=0 with level=8, and the excess offers ignored.
REQ-032 At level=8 mid-frame, assert valid at the STOP-end pop cycle -> push accepted next cycle after ready rises, and level stays <=8.
REQ-033 Assert reset at cycle 10 of a 0x3C frame -> tx=1, level=0, and busy=0 next edge; then push 0x81 -> a clean frame.
REQ-034 Hold valid while simultaneously popping at level=1 -> level stays 1 and byte order is preserved.
